uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter among NUM_REQ byte sources (motor status reporter, command ACK, debug).
//  Selects one requester per byte, round-robin, and drives the transmitter's tx_start/to_tx/busy interface.
//  Multi-byte frames are kept contiguous: a requester keeps the transmitter until it sends a byte with req_last=1.
//  Detects a transmitter that never raises busy.
// PARAMETERS
//  NUM_REQ       2     number of requesters (2..8)
//  BUSY_TIMEOUT  16    cycles to wait for tx_busy to rise after tx_start before flagging an error
// PORTS
//  clk          in   1          system clock (16 MHz)
//  rst_n        in   1          reset, synchronous, active-low
//  req_valid    in   NUM_REQ    per-requester byte valid; held until the matching req_ready is seen
//  req_data     in   8*NUM_REQ  byte i at [8*i+7:8*i]
//  req_last     in   NUM_REQ    byte is the last of its frame
//  req_ready    out  NUM_REQ    one-hot accept; transfer happens when valid&&ready in the same cycle
//  tx_start     out  1          one-cycle start pulse to the transmitter
//  to_tx        out  8          byte to the transmitter; stable from START until return to IDLE
//  tx_busy      in   1          transmitter busy flag
//  grant_id     out  clog2(NUM_REQ)  index of the current/last granted requester
//  arb_busy     out  1          high whenever state != IDLE or a frame lock is held
//  timeout_err  out  1          sticky; set on busy timeout; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; tx_start=0; to_tx=0; req_ready=0; grant_id=0; arb_busy=0;
//   timeout_err=0; rr_ptr=0; lock=0. A transmitter byte already in flight is not aborted.
//  FSM states: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: candidates are all requesters, or only grant_id if lock=1.
//   Winner = first valid candidate scanning from rr_ptr upward with wrap.
//   req_ready[winner]=1 combinationally, in the IDLE state only.
//   On transfer: latch to_tx=req_data[winner] and grant_id=winner; lock <= ~req_last[winner]; go START.
//  START: tx_start=1 for exactly this cycle; go WAIT_BUSY; timeout counter cleared.
//  WAIT_BUSY: tx_busy=1 -> WAIT_DONE. The transmitter raises busy 2 cycles after tx_start.
//   If the counter reaches BUSY_TIMEOUT-1 with tx_busy=0: set timeout_err, clear lock, go IDLE.
//  WAIT_DONE: tx_busy=0 -> IDLE.
//   If lock=0 on exit: rr_ptr <= (grant_id+1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
//  Throughput: 1 byte per (11*1667 + ~4) cycles at 9600 baud. Accept-to-tx_start latency is 1 cycle.
//  Boundary conditions:
//   - Simultaneous valids: rr order, no starvation; each requester is served within NUM_REQ frames.
//   - Locked with no valid from the owner: arbiter waits indefinitely in IDLE; others are blocked.
//   - req_valid deasserted before ready: protocol violation, no effect.
//   - NUM_REQ=1: always grant 0.
//   - tx_busy already high in IDLE (external user): no new grant until it falls.
// CONFIGURATION
//  UART_ARB_FIXED_PRIO_EN defined: winner is the lowest-index valid candidate; rr_ptr is removed.
//   Frame lock still applies.
//  Undefined (default): round-robin as above.
// STRUCTURE
//  Shared package/include uart_pkg.vh holds:
//   - FSM state codes ARB_IDLE/ARB_START/ARB_WAIT_BUSY/ARB_WAIT_DONE (2-bit)
//   - UART_DATA_W=8
//   - BAUD_BIT=1667, reused by the transmitter and the receiver
//  One sub-module, uart_rr_pick: combinational masked priority pick (req, mask_ptr -> one-hot, index).
//  FSM, counter and lock stay in the top.
// TESTING (bench uses a transmitter model: busy rises 2 cycles after tx_start and holds for 20 cycles)
//  1. Single byte: req_valid=01, data0=0xA5, last=1
//     -> ready0 for 1 cycle; tx_start 1 cycle later; to_tx=0xA5 held; back to IDLE after busy falls.
//  2. Round-robin: both valid continuously, last=1, data0=0x11, data1=0x22
//     -> to_tx sequence 0x11,0x22,0x11,0x22.
//  3. Frame lock: req0 sends 0x01(last=0),0x02,0x03(last=1) while req1 is valid with 0x55
//     -> to_tx 0x01,0x02,0x03,0x55; req1 is never granted mid-frame.
//  4. Busy timeout: model never raises busy
//     -> timeout_err=1 exactly BUSY_TIMEOUT cycles after tx_start; FSM returns to IDLE and serves the next request.
//  5. Reset mid-WAIT_DONE: rst_n=0 for 1 cycle -> next cycle all outputs at reset values, lock=0, rr_ptr=0.
//  6. With UART_ARB_FIXED_PRIO_EN: both valid continuously -> only req0 is served while it stays valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit period, arbiter FSM state codes and a width helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int BAUD_BIT    = 1667;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    // Index width that stays legal (>= 1 bit) even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Masked priority pick: first set bit of req scanning upward from mask_ptr with wrap.
module uart_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] mask_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    // NOTE: every combinational output gets a default before the scan so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(mask_ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources with frame lock and busy timeout.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             tx_start,
    output logic [UART_DATA_W-1:0]           to_tx,
    input  logic                             tx_busy,
    output logic [idx_width(NUM_REQ)-1:0]    grant_id,
    output logic                             arb_busy,
    output logic                             timeout_err
);

    localparam int ID_W  = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(BUSY_TIMEOUT);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic                   lock;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [NUM_REQ-1:0]     cand;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]        pick_idx;
    logic [ID_W-1:0]        pick_ptr;
    logic                   pick_any;
    logic                   accept;
    logic                   tmo_hit;
    logic [UART_DATA_W-1:0] data_sel;

    // While a frame is open only its owner may compete.
    assign cand     = lock ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
    assign data_sel = req_data[UART_DATA_W*pick_idx +: UART_DATA_W];
    assign arb_busy = (state != ARB_IDLE) || lock;

    uart_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req      (cand),
        .mask_ptr (pick_ptr),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

`ifdef UART_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr;
    logic            rr_advance;

    assign pick_ptr   = rr_ptr;
    assign rr_advance = (state == ARB_WAIT_DONE) && !tx_busy && !lock;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (rr_advance) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        tx_start  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ARB_IDLE: begin
                // An external user holding tx_busy also blocks new grants.
                if (rst_n && !tx_busy) begin
                    req_ready = pick_grant;
                    accept    = pick_any;
                end
                if (accept) begin
                    state_nxt = ARB_START;
                end
            end
            ARB_START: begin
                tx_start  = 1'b1;
                state_nxt = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                // Counter reaches BUSY_TIMEOUT-1 on the same edge the error is flagged,
                // which lands the flag exactly BUSY_TIMEOUT cycles after tx_start rose.
                if (tx_busy) begin
                    state_nxt = ARB_WAIT_DONE;
                end else if (tmo_cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // NOTE: synchronous reset lives inside the clocked block; all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_tx       <= '0;
            grant_id    <= '0;
            lock        <= 1'b0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                to_tx    <= data_sel;
                grant_id <= pick_idx;
                lock     <= ~req_last[pick_idx];
            end
            if (state == ARB_START) begin
                tmo_cnt <= '0;
            end else if (state == ARB_WAIT_BUSY && !tx_busy) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // A dead transmitter must not leave other requesters locked out.
            if (tmo_hit) begin
                timeout_err <= 1'b1;
                lock        <= 1'b0;
            end
        end
    end

endmodule
